// File: rtl/rca_seq_ctrl_pkg.sv
// rca_seq_ctrl_pkg: shared types and constants for the nibble-serial adder
// controller.
//   state_e  : controller FSM states
//   SLICE_W  : width of the shared ripple-carry slice
//   idx_w()  : bit width of the slice index counter (never less than 1)
package rca_seq_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-slice build still needs a 1-bit counter to have a legal vector.
  function automatic int idx_w(input int nslice);
    int w;
    w = $clog2(nslice);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_add4_slice.sv
// add4_slice: 4-bit combinational ripple-carry adder built from four
// full-adder cells.
//   x, y : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   cout : carry out of bit 3
module add4_slice
  import rca_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    logic p;
    assign p      = x[i] ^ y[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (p & c[i]);
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: adds two WIDTH-bit unsigned operands by iterating one shared
// 4-bit ripple-carry slice over the operands, least significant nibble first.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin sampled on accept)
//   out_valid/ out_ready: result handshake
//   sum                 : WIDTH+1 bit result, sum[WIDTH] is the final carry
//   busy                : high while an operation is in flight (RUN or DONE)
module rca_seq_ctrl
  import rca_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_w(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     sum_q, sum_d;

  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] nib_a, nib_b, nib_s;
  logic               nib_cout;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (idx_q == IDX_LAST);

  // Operand nibble select feeding the single shared slice.
  assign nib_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign nib_b = b_q[idx_q*SLICE_W +: SLICE_W];

  add4_slice u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs are decoded straight from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
  end

  // Datapath next-state: capture on accept, one nibble per RUN cycle.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
      sum_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q*SLICE_W +: SLICE_W] = nib_s;
      carry_d = nib_cout;
      if (last) begin
        // Final carry lands in the extra MSB; the counter parks at 0 so a
        // non-power-of-two slice count never walks past the operands.
        sum_d[WIDTH] = nib_cout;
        idx_d        = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
module tb_rca_seq_ctrl;

  logic clk;
  logic rst_n;

  // WIDTH=16 instance
  logic        iv16, ir16, ov16, or16, ci16, bz16;
  logic [15:0] a16, b16;
  logic [16:0] s16;

  // WIDTH=4 instance
  logic        iv4, ir4, ov4, or4, ci4, bz4;
  logic [3:0]  a4, b4;
  logic [4:0]  s4;

  int n_tests = 0;
  int n_fail  = 0;

  rca_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .busy(bz16)
  );

  rca_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(ci4), .out_valid(ov4), .out_ready(or4),
    .sum(s4), .busy(bz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w4;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Snapshot of {in_ready, out_valid, busy} for the selected instance.
  function automatic logic [2:0] flags(input bit w4);
    return w4 ? {ir4, ov4, bz4} : {ir16, ov16, bz16};
  endfunction

  function automatic logic [16:0] sumv(input bit w4);
    return w4 ? {12'd0, s4} : s16;
  endfunction

  // One full operation with out_ready held high; checks latency and result.
  task automatic run_op(input bit w4, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [16:0] exp, input string nm);
    int n;
    int t;
    n = w4 ? 1 : 4;
    t = 0;
    while (flags(w4)[2] !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk({nm, "_ready"}, 32'(flags(w4)[2]), 32'd1);
    @(negedge clk);
    if (w4) begin iv4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; ci4 = ci; end
    else    begin iv16 = 1'b1; a16 = av; b16 = bv; ci16 = ci; end
    @(posedge clk); #1;
    iv4 = 1'b0; iv16 = 1'b0;
    // Scramble operands after the accept edge; they must be ignored.
    a16 = ~av; b16 = 16'h5A5A; a4 = ~av[3:0]; b4 = 4'h6;
    chk({nm, "_accept"}, 32'(flags(w4)), 32'b001);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      chk({nm, "_run"}, 32'(flags(w4)), 32'b001);
    end
    @(posedge clk); #1;
    chk({nm, "_done"}, 32'(flags(w4)), 32'b011);
    chk({nm, "_sum"}, 32'(sumv(w4)), 32'(exp));
    @(posedge clk); #1;
    chk({nm, "_idle"}, 32'(flags(w4)), 32'b100);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'h1234, 16'h4321, 1'b0, 17'h05555};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 17'h00001};
    vecs[5]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[6]  = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 17'h01000};
    vecs[7]  = '{1'b1, 16'h000F, 16'h0001, 1'b1, 17'h00011};
    vecs[8]  = '{1'b1, 16'h0007, 16'h0008, 1'b0, 17'h0000F};
    vecs[9]  = '{1'b1, 16'h000F, 16'h000F, 1'b1, 17'h0001F};
    vecs[10] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 17'h00000};

    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; or16 = 1'b1;
    iv4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0; or4  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst16_flags", 32'(flags(1'b0)), 32'b100);
    chk("rst16_sum",   32'(s16), 32'd0);
    chk("rst4_flags",  32'(flags(1'b1)), 32'b100);
    chk("rst4_sum",    32'(s4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp,
             $sformatf("vec%0d", i));

    // Backpressure: result held in DONE while out_ready is low.
    or16 = 1'b0;
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_done", 32'(flags(1'b0)), 32'b011);
    chk("bp_sum",  32'(s16), 32'h0FFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = ~ci16; iv16 = ~iv16;
      @(posedge clk); #1;
      chk("bp_hold_flags", 32'(flags(1'b0)), 32'b011);
      chk("bp_hold_sum",   32'(s16), 32'h0FFFF);
    end
    @(negedge clk);
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(flags(1'b0)), 32'b100);

    // Reset during RUN aborts without a result.
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre", 32'(flags(1'b0)), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", 32'(flags(1'b0)), 32'b100);
    chk("abort_sum",   32'(s16), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(ov16), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 17'h00002, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
